// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: packs field-level requests into 32-bit
// machine words and hands them, with their byte address, to instruction memory.
module instr_encoder #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        cls,
   input  logic [4:0]        rd,
   input  logic [4:0]        rs1,
   input  logic [4:0]        rs2,
   input  logic [2:0]        funct3,
   input  logic              f7b5,
   input  logic [31:0]       imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err_pulse,
   output logic              err_flag,
   output logic [CNT_W-1:0]  word_count
);

   localparam logic [2:0] CLS_LOAD   = 3'd0;
   localparam logic [2:0] CLS_STORE  = 3'd1;
   localparam logic [2:0] CLS_R      = 3'd2;
   localparam logic [2:0] CLS_BRANCH = 3'd3;
   localparam logic [2:0] CLS_IALU   = 3'd4;
   localparam logic [2:0] CLS_JAL    = 3'd5;

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [31:0]       instr_q, instr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              errPulse_q, errPulse_d;
   logic              errFlag_q, errFlag_d;

   logic [31:0] encWord;
   logic        legal;
   logic        accept;
   logic        xfer;
   logic        fitsI, fitsB, fitsJ;

   // A signed immediate fits in N bits when every bit above bit N-1 matches the sign.
   assign fitsI = (imm[31:11] == '0) || (imm[31:11] == '1);
   assign fitsB = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];
   assign fitsJ = ((imm[31:20] == '0) || (imm[31:20] == '1)) && !imm[0];

   always_comb begin
      encWord = 32'h0;
      legal   = 1'b0;
      case (cls)
         CLS_LOAD: begin
            encWord = {imm[11:0], rs1, funct3, rd, 7'b0000011};
            legal   = fitsI;
         end
         CLS_STORE: begin
            encWord = {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011};
            legal   = fitsI;
         end
         CLS_R: begin
            encWord = {1'b0, f7b5, 5'b00000, rs2, rs1, funct3, rd, 7'b0110011};
            legal   = 1'b1;
         end
         CLS_BRANCH: begin
            encWord = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
            legal   = fitsB;
         end
         CLS_IALU: begin
            encWord = {imm[11:0], rs1, funct3, rd, 7'b0010011};
            legal   = fitsI;
         end
         CLS_JAL: begin
            encWord = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
            legal   = fitsJ;
         end
         default: begin
            encWord = 32'h0;
            legal   = 1'b0;
         end
      endcase
   end

   assign in_ready = !clear && ((state_q == EMPTY) || out_ready);
   assign accept   = in_valid && in_ready;
   assign xfer     = (state_q == FULL) && out_ready && !clear;

   // The address register always names the slot of the held or next word, so a
   // word loaded on a transfer edge picks up the already-incremented address.
   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      addr_d     = addr_q;
      count_d    = count_q;
      errPulse_d = 1'b0;
      errFlag_d  = errFlag_q;
      if (clear) begin
         state_d   = EMPTY;
         addr_d    = ADDR_W'(BASE_ADDR);
         count_d   = '0;
         errFlag_d = 1'b0;
      end else begin
         if (xfer) begin
            state_d = EMPTY;
            addr_d  = addr_q + ADDR_W'(4);
            if (count_q != '1) begin
               count_d = count_q + CNT_W'(1);
            end
         end
         if (accept && legal) begin
            state_d = FULL;
            instr_d = encWord;
         end
         if (accept && !legal) begin
            errPulse_d = 1'b1;
            errFlag_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= EMPTY;
         instr_q    <= 32'h0;
         addr_q     <= ADDR_W'(BASE_ADDR);
         count_q    <= '0;
         errPulse_q <= 1'b0;
         errFlag_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         errPulse_q <= errPulse_d;
         errFlag_q  <= errFlag_d;
      end
   end

   assign out_valid  = (state_q == FULL);
   assign out_instr  = instr_q;
   assign out_addr   = addr_q;
   assign err_pulse  = errPulse_q;
   assign err_flag   = errFlag_q;
   assign word_count = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: encodings, handshake, errors, wrap,
// clear and asynchronous reset, with hand-computed expected words.
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  cls = 3'd0;
   logic [4:0]  rd = 5'd0;
   logic [4:0]  rs1 = 5'd0;
   logic [4:0]  rs2 = 5'd0;
   logic [2:0]  funct3 = 3'd0;
   logic        f7b5 = 1'b0;
   logic [31:0] imm = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [7:0]  out_addr;
   logic        err_pulse;
   logic        err_flag;
   logic [15:0] word_count;

   logic        inReady4, outValid4, errPulse4, errFlag4;
   logic [31:0] outInstr4;
   logic [3:0]  outAddr4;
   logic [1:0]  wordCount4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_encoder dut (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .cls(cls), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .f7b5(f7b5), .imm(imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
      .err_pulse(err_pulse), .err_flag(err_flag), .word_count(word_count)
   );

   // Narrow instance shares the stimulus to exercise address wrap and count saturation.
   instr_encoder #(.ADDR_W(4), .BASE_ADDR(0), .CNT_W(2)) dut4 (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(inReady4),
      .cls(cls), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .f7b5(f7b5), .imm(imm),
      .out_valid(outValid4), .out_ready(out_ready), .out_instr(outInstr4), .out_addr(outAddr4),
      .err_pulse(errPulse4), .err_flag(errFlag4), .word_count(wordCount4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setReq(input logic [2:0] c, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] f3, input logic f7,
                         input logic [31:0] im);
      cls = c; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; f7b5 = f7; imm = im;
   endtask

   task automatic doClear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b exp 0", out_valid); end
      checks++; if (out_instr !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr got %h exp 0", out_instr); end
      checks++; if (out_addr !== 8'h00) begin errors++; $display("[TB] FAIL rst_addr got %h exp 00", out_addr); end
      checks++; if (err_pulse !== 1'b0 || err_flag !== 1'b0) begin errors++; $display("[TB] FAIL rst_err got %b%b exp 00", err_pulse, err_flag); end
      checks++; if (word_count !== 16'd0) begin errors++; $display("[TB] FAIL rst_count got %0d exp 0", word_count); end
      reset = 1'b0;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_load();
      out_ready = 1'b0;
      setReq(3'd0, 5'd6, 5'd9, 5'd0, 3'b010, 1'b0, -32'sd4);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL load_valid got %b exp 1", out_valid); end
      checks++; if (out_instr !== 32'hFFC4A303) begin errors++; $display("[TB] FAIL load_instr got %h exp FFC4A303", out_instr); end
      checks++; if (out_addr !== 8'h00) begin errors++; $display("[TB] FAIL load_addr got %h exp 00", out_addr); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL load_in_ready got %b exp 0", in_ready); end
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0 || out_addr !== 8'h04 || word_count !== 16'd1) begin
         errors++; $display("[TB] FAIL load_xfer got v=%b a=%h c=%0d exp v=0 a=04 c=1", out_valid, out_addr, word_count); end
   endtask

   task automatic test_back_to_back();
      doClear();
      checks++; if (out_addr !== 8'h00 || word_count !== 16'd0) begin
         errors++; $display("[TB] FAIL b2b_clear got a=%h c=%0d exp a=00 c=0", out_addr, word_count); end
      out_ready = 1'b1;
      setReq(3'd1, 5'd0, 5'd9, 5'd6, 3'b010, 1'b0, 32'd8);
      in_valid = 1'b1;
      tick();
      checks++; if (out_instr !== 32'h0064A423 || out_addr !== 8'h00 || out_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL b2b_store got %h@%h v=%b exp 0064A423@00 v=1", out_instr, out_addr, out_valid); end
      setReq(3'd2, 5'd4, 5'd5, 5'd6, 3'b110, 1'b0, 32'd0);
      tick();
      in_valid = 1'b0;
      checks++; if (out_instr !== 32'h0062E233 || out_addr !== 8'h04 || out_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL b2b_rtype got %h@%h v=%b exp 0062E233@04 v=1", out_instr, out_addr, out_valid); end
      tick();
      checks++; if (word_count !== 16'd2 || out_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL b2b_count got c=%0d v=%b exp c=2 v=0", word_count, out_valid); end
   endtask

   task automatic test_encodings();
      logic [2:0]  c [5];
      logic [4:0]  d [5];
      logic [4:0]  s1 [5];
      logic [4:0]  s2 [5];
      logic        f7 [5];
      logic [31:0] im [5];
      logic [31:0] exp [5];
      c[0] = 3'd2; d[0] = 5'd1; s1[0] = 5'd2; s2[0] = 5'd3; f7[0] = 1'b1; im[0] = 32'd0;  exp[0] = 32'h403100B3;
      c[1] = 3'd3; d[1] = 5'd0; s1[1] = 5'd0; s2[1] = 5'd0; f7[1] = 1'b0; im[1] = 32'd8;  exp[1] = 32'h00000463;
      c[2] = 3'd5; d[2] = 5'd1; s1[2] = 5'd0; s2[2] = 5'd0; f7[2] = 1'b0; im[2] = 32'd16; exp[2] = 32'h010000EF;
      c[3] = 3'd4; d[3] = 5'd1; s1[3] = 5'd0; s2[3] = 5'd0; f7[3] = 1'b0; im[3] = 32'd5;  exp[3] = 32'h00500093;
      c[4] = 3'd3; d[4] = 5'd0; s1[4] = 5'd0; s2[4] = 5'd0; f7[4] = 1'b0; im[4] = -32'sd4096; exp[4] = 32'h80000063;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         setReq(c[i], d[i], s1[i], s2[i], 3'b000, f7[i], im[i]);
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         checks++; if (out_valid !== 1'b1 || out_instr !== exp[i]) begin
            errors++; $display("[TB] FAIL enc_%0d got %h v=%b exp %h v=1", i, out_instr, out_valid, exp[i]); end
         tick();
      end
   endtask

   task automatic test_backpressure();
      doClear();
      out_ready = 1'b0;
      setReq(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
      in_valid = 1'b1;
      tick();
      setReq(3'd0, 5'd6, 5'd9, 5'd0, 3'b010, 1'b0, -32'sd4);
      for (int i = 0; i < 5; i++) begin
         checks++; if (in_ready !== 1'b0 || out_instr !== 32'h00500093 || out_addr !== 8'h00 || out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL bp_hold_%0d got r=%b %h@%h exp r=0 00500093@00", i, in_ready, out_instr, out_addr); end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready got %b exp 1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_instr !== 32'hFFC4A303 || out_addr !== 8'h04 || word_count !== 16'd1) begin
         errors++; $display("[TB] FAIL bp_handoff got v=%b %h@%h c=%0d exp v=1 FFC4A303@04 c=1", out_valid, out_instr, out_addr, word_count); end
      tick();
      checks++; if (out_valid !== 1'b0 || word_count !== 16'd2 || out_addr !== 8'h08) begin
         errors++; $display("[TB] FAIL bp_drain got v=%b c=%0d a=%h exp v=0 c=2 a=08", out_valid, word_count, out_addr); end
   endtask

   task automatic test_errors();
      logic [2:0]  c [3];
      logic [31:0] im [3];
      doClear();
      out_ready = 1'b1;
      c[0] = 3'd4; im[0] = 32'd2048;
      c[1] = 3'd3; im[1] = 32'd7;
      c[2] = 3'd6; im[2] = 32'd0;
      for (int i = 0; i < 3; i++) begin
         setReq(c[i], 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, im[i]);
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         checks++; if (err_pulse !== 1'b1 || err_flag !== 1'b1 || out_valid !== 1'b0 || out_addr !== 8'h00 || word_count !== 16'd0) begin
            errors++; $display("[TB] FAIL err_rej_%0d got p=%b f=%b v=%b a=%h c=%0d exp p=1 f=1 v=0 a=00 c=0",
                               i, err_pulse, err_flag, out_valid, out_addr, word_count); end
         tick();
         checks++; if (err_pulse !== 1'b0 || err_flag !== 1'b1) begin
            errors++; $display("[TB] FAIL err_pulse_end_%0d got p=%b f=%b exp p=0 f=1", i, err_pulse, err_flag); end
      end
      setReq(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, -32'sd2048);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (err_pulse !== 1'b0 || out_valid !== 1'b1 || out_instr !== 32'h80000093) begin
         errors++; $display("[TB] FAIL err_edge_legal got p=%b v=%b %h exp p=0 v=1 80000093", err_pulse, out_valid, out_instr); end
      tick();
      doClear();
      checks++; if (err_flag !== 1'b0) begin errors++; $display("[TB] FAIL err_clear got %b exp 0", err_flag); end
   endtask

   task automatic test_wrap_restart();
      logic [3:0] expAddr;
      doClear();
      out_ready = 1'b1;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         setReq(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'(k));
         tick();
         expAddr = 4'(4 * k);
         checks++; if (outAddr4 !== expAddr || outValid4 !== 1'b1) begin
            errors++; $display("[TB] FAIL wrap_addr_%0d got %h v=%b exp %h v=1", k, outAddr4, outValid4, expAddr); end
      end
      in_valid = 1'b0;
      checks++; if (wordCount4 !== 2'd3 || word_count !== 16'd4 || out_addr !== 8'h10) begin
         errors++; $display("[TB] FAIL wrap_count got c4=%0d c=%0d a=%h exp c4=3 c=4 a=10", wordCount4, word_count, out_addr); end
      clear = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL clr_in_ready got %b exp 0", in_ready); end
      tick();
      clear = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_addr !== 8'h00 || word_count !== 16'd0) begin
         errors++; $display("[TB] FAIL clr_full got v=%b a=%h c=%0d exp v=0 a=00 c=0", out_valid, out_addr, word_count); end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b1;
      setReq(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd1);
      in_valid = 1'b1;
      tick();
      setReq(3'd7, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0);
      tick();
      out_ready = 1'b0;
      setReq(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd2);
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || err_flag !== 1'b1 || word_count !== 16'd1 || out_addr !== 8'h04) begin
         errors++; $display("[TB] FAIL mid_setup got v=%b f=%b c=%0d a=%h exp v=1 f=1 c=1 a=04", out_valid, err_flag, word_count, out_addr); end
      #2;
      reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_addr !== 8'h00 || word_count !== 16'd0 || err_flag !== 1'b0 || err_pulse !== 1'b0) begin
         errors++; $display("[TB] FAIL mid_reset got v=%b %h@%h c=%0d f=%b p=%b exp all zero",
                            out_valid, out_instr, out_addr, word_count, err_flag, err_pulse); end
      #2;
      reset = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_load();
      test_back_to_back();
      test_encodings();
      test_backpressure();
      test_errors();
      test_wrap_restart();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder for the single-cycle processor's program-load path, performing the inverse of the opcode/control decode. It accepts field-level instruction requests and packs them into 32-bit machine words for the supported classes: load, store, R-type, branch, I-ALU and JAL. It range-checks immediates and delivers each word with its instruction-memory byte address over a valid/ready stream. It sits between the test/boot program source and the instruction-memory write port.

## Interface
- ADDR_W, 8: width of out_addr; the address wraps modulo 2^ADDR_W.
- BASE_ADDR, 0: first byte address after reset or clear; must be a multiple of 4.
- CNT_W, 16: width of word_count.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous restart: drops the held word, sets address to BASE_ADDR, zeroes count and err_flag.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- cls  in  3  class: 0 LOAD, 1 STORE, 2 R-type, 3 BRANCH, 4 I-ALU, 5 JAL; 6 and 7 are illegal.
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  funct3 field, used by all classes except JAL.
- f7b5  in  1  funct7 bit 5; R-type only, all other funct7 bits are 0.
- imm  in  32  signed byte immediate or offset.
- out_valid  out  1  held word valid.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- out_instr  out  32  encoded word.
- out_addr  out  ADDR_W  byte address of out_instr.
- err_pulse  out  1  one-cycle pulse: the request accepted on the previous edge was rejected.
- err_flag  out  1  sticky error; cleared only by reset or clear.
- word_count  out  CNT_W  words transferred; saturates at all-ones.

## Operation
- Opcodes: LOAD 0000011, STORE 0100011, R 0110011, BRANCH 1100011, I-ALU 0010011, JAL 1101111.
- Encoding formats:
  - I-type (LOAD, I-ALU): imm[11:0], rs1, funct3, rd, op.
  - S-type: imm[11:5], rs2, rs1, funct3, imm[4:0], op.
  - R-type: {0, f7b5, 00000}, rs2, rs1, funct3, rd, op.
  - B-type: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op.
  - J-type: imm[20], imm[10:1], imm[11], imm[19:12], rd, op.
- Legal immediates (signed):
  - I-type and S-type: -2048..2047.
  - B-type: -4096..4094 and imm[0] == 0.
  - J-type: -1048576..1048574 and imm[0] == 0.
  - R-type ignores imm.
- Rejection: illegal cls or an out-of-range/odd immediate is consumed normally, but:
  - no word is produced;
  - out_addr and word_count are unchanged;
  - err_pulse is asserted for one cycle and err_flag is set.
- Single output register stage; state is EMPTY (out_valid = 0) or FULL (out_valid = 1).
  - EMPTY, legal accept → FULL.
  - FULL, out_ready with no legal accept → EMPTY.
  - FULL, out_ready with simultaneous legal accept → stays FULL, holding the new word.
  - FULL, !out_ready → stays FULL with out_instr/out_addr stable.
- Address and count:
  - After each output transfer, out_addr += 4, wrapping modulo 2^ADDR_W. A word loaded in the same cycle carries the incremented address.
  - word_count increments on each output transfer.
- clear: has priority over every handshake in the same cycle.
  - in_ready = 0 while clear is high.
  - A transfer coinciding with clear is discarded and not counted.

## Timing
- Reset values: out_valid 0, out_instr 0, out_addr BASE_ADDR, err_pulse 0, err_flag 0, word_count 0; in_ready is 1 once reset deasserts.
- in_ready = !clear && (!out_valid || out_ready); combinational from out_ready and clear only, never from in_valid.
- Latency: a request accepted at edge N drives out_valid/out_instr from edge N onward, visible in cycle N+1. err_pulse is high in cycle N+1 only.
- Throughput: one word per cycle while out_ready stays high.
- Reset asserted mid-transfer clears all state immediately, regardless of the clock.
- out_instr/out_addr change only on a load edge, never while out_valid && !out_ready.

## Test plan
- LOAD, rd 6, rs1 9, funct3 010, imm -4 → out_instr 0xFFC4A303, out_addr 0x00.
- Back-to-back: STORE (rs1 9, rs2 6, funct3 010, imm 8) then R-type (rd 4, rs1 5, rs2 6, funct3 110, f7b5 0), out_ready held high.
  - Words 0x0064A423 @0x00 and 0x0062E233 @0x04 on consecutive cycles.
  - word_count = 2.
- Encoding set:
  - R-type rd 1, rs1 2, rs2 3, funct3 000, f7b5 1 → 0x403100B3.
  - BRANCH rs1 0, rs2 0, funct3 000, imm 8 → 0x00000463.
  - JAL rd 1, imm 16 → 0x010000EF.
  - I-ALU rd 1, rs1 0, funct3 000, imm 5 → 0x00500093.
- Backpressure: with out_ready 0 for 5 cycles, a second request sees in_ready 0 and the held word stays stable. On out_ready 1, the handoff is seamless with no gap cycle.
- Errors:
  - I-ALU imm 2048 rejected; BRANCH imm 7 rejected; cls 6 rejected.
  - Each rejection: err_pulse for one cycle, err_flag stays high, out_addr/word_count unchanged.
  - clear → err_flag 0.
- Wrap and restart:
  - ADDR_W 4: the fifth word wraps from 0xC to 0x0.
  - clear while FULL → out_valid 0, out_addr BASE_ADDR, word_count 0.
  - reset asserted mid-stream → all outputs return to reset values asynchronously.
